// File: rtl/cam_reg_sequencer.sv
// Purpose: walks a {reg_addr, reg_data} table and issues camera register writes with NACK retry (CAM_SEQ_DELAY_EN adds delay entries).
// Latency: start or entry advance to cmd_valid is 2 cycles (fetch + decode); a delay entry adds reg_data*TICKS_PER_MS cycles.
// Backpressure: cmd_valid holds cmd_addr/cmd_data stable until cmd_ready; one write outstanding until rsp_valid.
module cam_reg_sequencer #(
  parameter  int ADDR_W       = 8,
  parameter  int DATA_W       = 8,
  parameter  int DEPTH        = 256,
  parameter  int MAX_RETRY    = 3,
  parameter  int TICKS_PER_MS = 25000,
  localparam int IDX_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic [IDX_W-1:0]         tbl_addr,
  input  logic [ADDR_W+DATA_W-1:0] tbl_data,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [ADDR_W-1:0]        cmd_addr,
  output logic [DATA_W-1:0]        cmd_data,
  input  logic                     rsp_valid,
  input  logic                     rsp_nack,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [IDX_W-1:0]         err_idx
);

  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, ISSUE, WAIT_RSP, DONE, ERR
`ifdef CAM_SEQ_DELAY_EN
    , DELAY
`endif
  } state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [RTY_W-1:0]  retry;
  logic [ADDR_W-1:0] ent_addr;
  logic [DATA_W-1:0] ent_data;
  logic              ent_end, idx_last;
  logic              seq_clr, idx_adv, rty_inc, cmd_ld, err_ld;

`ifdef CAM_SEQ_DELAY_EN
  // Sized so that (2^DATA_W-1)*TICKS_PER_MS cannot overflow.
  localparam int CNT_W = DATA_W + $clog2(TICKS_PER_MS + 1);
  logic [CNT_W-1:0] dly_cnt;
  logic             dly_ld;
`endif

  assign ent_addr = tbl_data[ADDR_W+DATA_W-1:DATA_W];
  assign ent_data = tbl_data[DATA_W-1:0];
  assign ent_end  = (&ent_addr) && (&ent_data);
  assign idx_last = (idx == IDX_W'(DEPTH - 1));

  assign tbl_addr  = idx;
  assign cmd_valid = (state == ISSUE);
  assign done      = (state == DONE);
  assign error     = (state == ERR);
  assign busy      = (state != IDLE) && (state != DONE) && (state != ERR);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and control strobes; start restarts from index 0 in every state.
  always_comb begin
    state_nxt = state;
    seq_clr   = 1'b0;
    idx_adv   = 1'b0;
    rty_inc   = 1'b0;
    cmd_ld    = 1'b0;
    err_ld    = 1'b0;
`ifdef CAM_SEQ_DELAY_EN
    dly_ld    = 1'b0;
`endif
    if (start) begin
      state_nxt = FETCH;
      seq_clr   = 1'b1;
    end else begin
      case (state)
        FETCH: state_nxt = DECODE;
        DECODE: begin
          if (ent_end) begin
            state_nxt = DONE;
`ifdef CAM_SEQ_DELAY_EN
          end else if (&ent_addr) begin
            state_nxt = DELAY;
            dly_ld    = 1'b1;
`endif
          end else begin
            state_nxt = ISSUE;
            cmd_ld    = 1'b1;
          end
        end
        ISSUE: if (cmd_ready) state_nxt = WAIT_RSP;
        WAIT_RSP: begin
          if (rsp_valid) begin
            if (!rsp_nack) begin
              idx_adv = 1'b1;
              if (idx_last) state_nxt = DONE;
              else          state_nxt = FETCH;
            end else if (retry < RTY_W'(MAX_RETRY)) begin
              rty_inc   = 1'b1;
              state_nxt = ISSUE;
            end else begin
              err_ld    = 1'b1;
              state_nxt = ERR;
            end
          end
        end
`ifdef CAM_SEQ_DELAY_EN
        DELAY: begin
          if (dly_cnt <= CNT_W'(1)) begin
            idx_adv = 1'b1;
            if (idx_last) state_nxt = DONE;
            else          state_nxt = FETCH;
          end
        end
`endif
        default: state_nxt = state;
      endcase
    end
  end

  // Table index, retry count, latched write and failing index; the index saturates at DEPTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      retry    <= '0;
      cmd_addr <= '0;
      cmd_data <= '0;
      err_idx  <= '0;
    end else begin
      if (seq_clr) begin
        idx   <= '0;
        retry <= '0;
      end else if (idx_adv) begin
        retry <= '0;
        if (!idx_last) idx <= idx + IDX_W'(1);
      end else if (rty_inc) begin
        retry <= retry + RTY_W'(1);
      end
      if (cmd_ld) begin
        cmd_addr <= ent_addr;
        cmd_data <= ent_data;
      end
      if (err_ld) err_idx <= idx;
    end
  end

`ifdef CAM_SEQ_DELAY_EN
  // Delay countdown; a zero-length delay still spends one cycle in DELAY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_cnt <= '0;
    end else if (dly_ld) begin
      dly_cnt <= CNT_W'(ent_data) * CNT_W'(TICKS_PER_MS);
    end else if ((state == DELAY) && (dly_cnt != '0)) begin
      dly_cnt <= dly_cnt - CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_cam_reg_sequencer.sv
// Purpose: bench for cam_reg_sequencer with a table ROM, a bus-master responder and a table-walk reference model.
// Latency: ROM data follows tbl_addr by one clock; responses arrive rsp_lat cycles after each handshake.
// Backpressure: cmd_ready is held high, held low, or randomised per cycle depending on the test.
module tb_cam_reg_sequencer;
  localparam int DEPTH     = 16;
  localparam int MAX_RETRY = 3;
  localparam int TPM       = 10;
  localparam int IW        = 4;
`ifdef CAM_SEQ_DELAY_EN
  localparam bit DLY = 1'b1;
`else
  localparam bit DLY = 1'b0;
`endif

  logic          clk, rst_n, start;
  logic [IW-1:0] tbl_addr;
  logic [15:0]   tbl_data;
  logic          cmd_valid, cmd_ready;
  logic [7:0]    cmd_addr, cmd_data;
  logic          rsp_valid, rsp_nack;
  logic          busy, done, error;
  logic [IW-1:0] err_idx;

  cam_reg_sequencer #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY), .TICKS_PER_MS(TPM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_nack(rsp_nack),
    .busy(busy), .done(done), .error(error), .err_idx(err_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog");
  end

  logic [15:0] rom [DEPTH];
  int          n_cmp = 0, n_bad = 0, cyc = 0;
  logic [7:0]  wlog_a[$], wlog_d[$];
  int          hs_cyc[$];
  logic [7:0]  exp_a[$], exp_d[$];
  bit          exp_err;
  int          exp_eidx;
  bit          nack_list [64];
  int          nack_n, nack_ptr, nack_idx, rsp_lat, pcnt, seen_max;
  bit          pend, pnack;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // One clock: log handshakes, emulate the ROM and the bus master, track the highest index fetched.
  task automatic step();
    logic          hs;
    logic [IW-1:0] ta;
    hs = cmd_valid && cmd_ready;
    ta = tbl_addr;
    if (hs) begin
      wlog_a.push_back(cmd_addr);
      wlog_d.push_back(cmd_data);
      hs_cyc.push_back(cyc);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    tbl_data  = rom[ta];
    rsp_valid = 1'b0;
    rsp_nack  = 1'b0;
    if (hs) begin
      pend  = 1'b1;
      pcnt  = rsp_lat;
      pnack = (int'(ta) == nack_idx) || (nack_ptr < nack_n && nack_list[nack_ptr]);
      nack_ptr++;
    end
    if (pend) begin
      pcnt--;
      if (pcnt <= 0) begin
        rsp_valid = 1'b1;
        rsp_nack  = pnack;
        pend      = 1'b0;
      end
    end
    if (int'(tbl_addr) > seen_max) seen_max = int'(tbl_addr);
  endtask

  // Expected write stream and outcome, walking the table entry by entry.
  function automatic void model();
    logic [7:0] a, d;
    bit         ok;
    int         k, i;
    exp_a.delete(); exp_d.delete();
    exp_err = 1'b0; exp_eidx = 0; k = 0; i = 0;
    while (i < DEPTH) begin
      a = rom[i][15:8];
      d = rom[i][7:0];
      if (a == 8'hFF && d == 8'hFF) return;
      if (DLY && a == 8'hFF) begin
        i++;
        continue;
      end
      ok = 1'b0;
      for (int r = 0; r <= MAX_RETRY && !ok; r++) begin
        exp_a.push_back(a);
        exp_d.push_back(d);
        ok = !((i == nack_idx) || (k < nack_n && nack_list[k]));
        k++;
      end
      if (!ok) begin
        exp_err  = 1'b1;
        exp_eidx = i;
        return;
      end
      i++;
    end
  endfunction

  task automatic start_seq();
    wlog_a.delete(); wlog_d.delete(); hs_cyc.delete();
    nack_ptr = 0;
    seen_max = 0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, input bit rnd);
    int c = 0;
    while (!(done || error) && c < budget) begin
      if (rnd) cmd_ready = ($urandom_range(0, 3) != 0);
      step();
      c++;
    end
    cmd_ready = 1'b1;
    chk("finished", done || error, 1);
  endtask

  task automatic compare_model(input string tag);
    chk({tag, "_nwr"}, wlog_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < wlog_a.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wlog_a[i], exp_a[i]);
      chk($sformatf("%s_data%0d", tag, i), wlog_d[i], exp_d[i]);
    end
    chk({tag, "_done"}, done, !exp_err);
    chk({tag, "_error"}, error, exp_err);
    if (exp_err) chk({tag, "_err_idx"}, err_idx, exp_eidx);
    chk({tag, "_busy"}, busy, 0);
  endtask

  typedef struct {
    logic [15:0] e0;
    logic [15:0] e1;
    int          lat;
    int          nwr_plain;
    int          nwr_dly;
  } vec_t;

  initial begin
    vec_t vt[6];
    int   c, n12;

    vt[0] = '{16'h1280, 16'h1204, 2, 2, 2};
    vt[1] = '{16'hFFFF, 16'h1204, 1, 0, 0};
    vt[2] = '{16'h00FF, 16'hFFFF, 3, 1, 1};
    vt[3] = '{16'hFF03, 16'h5555, 1, 2, 1};
    vt[4] = '{16'hFF00, 16'hFFFF, 1, 1, 0};
    vt[5] = '{16'hFEFF, 16'hFF01, 2, 2, 1};

    rst_n = 1'b0; start = 1'b0; cmd_ready = 1'b1;
    rsp_valid = 1'b0; rsp_nack = 1'b0; tbl_data = '0;
    pend = 1'b0; pcnt = 0; pnack = 1'b0;
    nack_idx = -1; nack_n = 0; nack_ptr = 0; rsp_lat = 1; seen_max = 0;
    for (int i = 0; i < DEPTH; i++) rom[i] = 16'hFFFF;

    // Reset values, then idle after release.
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_tbl_addr", tbl_addr, 0);
    chk("rst_cmd_addr", cmd_addr, 0);
    chk("rst_cmd_data", cmd_data, 0);
    chk("rst_err_idx", err_idx, 0);
    rst_n = 1'b1;
    repeat (3) step();
    chk("idle_busy", busy, 0);
    chk("idle_cmd_valid", cmd_valid, 0);

    // Short tables: two entries followed by end markers.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < DEPTH; i++) rom[i] = 16'hFFFF;
      rom[0] = vt[v].e0;
      rom[1] = vt[v].e1;
      rsp_lat = vt[v].lat; nack_n = 0; nack_idx = -1;
      model();
      start_seq();
      wait_end(2000, 1'b0);
      chk($sformatf("vec%0d_nwr_tbl", v), wlog_a.size(), DLY ? vt[v].nwr_dly : vt[v].nwr_plain);
      compare_model($sformatf("vec%0d", v));
    end

    // Backpressure: cmd_ready low for 5 cycles while a write is pending.
    for (int i = 0; i < DEPTH; i++) rom[i] = 16'hFFFF;
    rom[0] = 16'h1280;
    rsp_lat = 2; nack_n = 0; nack_idx = -1;
    cmd_ready = 1'b0;
    start_seq();
    c = 0;
    while (!cmd_valid && c < 10) begin
      step();
      c++;
    end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold_valid%0d", k), cmd_valid, 1);
      chk($sformatf("hold_addr%0d", k), cmd_addr, 8'h12);
      chk($sformatf("hold_data%0d", k), cmd_data, 8'h80);
      step();
    end
    cmd_ready = 1'b1;
    wait_end(200, 1'b0);
    chk("hold_nwr", wlog_a.size(), 1);
    chk("hold_done", done, 1);

    // Entry 2 always NACKs: four attempts, then error at index 2 without fetching entry 3.
    for (int i = 0; i < DEPTH; i++) rom[i] = {8'(8'h10 + i), 8'(i * 7)};
    rom[8] = 16'hFFFF;
    rsp_lat = 1; nack_n = 0; nack_idx = 2;
    model();
    start_seq();
    wait_end(500, 1'b0);
    compare_model("retry");
    n12 = 0;
    foreach (wlog_a[i]) if (wlog_a[i] == 8'h12) n12++;
    chk("retry_attempts_e2", n12, MAX_RETRY + 1);
    chk("retry_err_idx", err_idx, 2);
    chk("retry_max_fetch", seen_max, 2);
    nack_idx = -1;

    // Reset asserted while a write is being offered.
    for (int i = 0; i < DEPTH; i++) rom[i] = 16'hFFFF;
    rom[0] = 16'h1280;
    cmd_ready = 1'b0;
    start_seq();
    c = 0;
    while (!cmd_valid && c < 10) begin
      step();
      c++;
    end
    chk("arst_pre_valid", cmd_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_cmd_valid", cmd_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_error", error, 0);
    chk("arst_err_idx", err_idx, 0);
    chk("arst_tbl_addr", tbl_addr, 0);
    chk("arst_cmd_addr", cmd_addr, 0);
    chk("arst_cmd_data", cmd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    repeat (4) step();
    chk("arst_idle_busy", busy, 0);
    chk("arst_idle_nwr", wlog_a.size(), 0);

    // No end marker: every entry written, index does not wrap.
    for (int i = 0; i < DEPTH; i++) rom[i] = {8'(8'h20 + i), 8'(8'hC0 + i)};
    rsp_lat = 1; nack_n = 0;
    model();
    start_seq();
    wait_end(1000, 1'b0);
    compare_model("full");
    chk("full_nwr_depth", wlog_a.size(), DEPTH);
    chk("full_no_wrap", tbl_addr != 0, 1);

    // Restart while waiting for the response of entry 5; the late response must be dropped.
    for (int i = 0; i < DEPTH; i++) rom[i] = (i < 10) ? {8'(8'h40 + i), 8'(8'hA0 + i)} : 16'hFFFF;
    rsp_lat = 3; nack_n = 0;
    model();
    start_seq();
    c = 0;
    while (wlog_a.size() < 6 && c < 300) begin
      step();
      c++;
    end
    chk("abort_reached_e5", wlog_a.size(), 6);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("abort_tbl_addr", tbl_addr, 0);
    chk("abort_cmd_valid", cmd_valid, 0);
    chk("abort_busy", busy, 1);
    wait_end(500, 1'b0);
    chk("abort_total", wlog_a.size(), 6 + exp_a.size());
    repeat (6) if (wlog_a.size() > 0) begin
      void'(wlog_a.pop_front());
      void'(wlog_d.pop_front());
    end
    compare_model("abort");

`ifdef CAM_SEQ_DELAY_EN
    // Delay entry of 3 ms between two writes.
    for (int i = 0; i < DEPTH; i++) rom[i] = 16'hFFFF;
    rom[0] = 16'h1111; rom[1] = 16'hFF03; rom[2] = 16'h2222;
    rsp_lat = 1; nack_n = 0;
    model();
    start_seq();
    wait_end(500, 1'b0);
    compare_model("dly");
    if (hs_cyc.size() == 2) chk("dly_gap", hs_cyc[1] - hs_cyc[0], 4 + 2 + 3 * TPM);
    else chk("dly_hs_count", hs_cyc.size(), 2);
`endif

    // Random tables, random NACKs, random backpressure and response latency.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < DEPTH; i++) begin
        logic [7:0] a, d;
        a = 8'($urandom_range(0, 255));
        d = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 5) == 0) a = 8'hFF;
        if (a == 8'hFF) d = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom_range(0, 4));
        rom[i] = {a, d};
      end
      nack_n = 64;
      for (int k = 0; k < 64; k++) nack_list[k] = ($urandom_range(0, 3) == 0);
      nack_idx = -1;
      rsp_lat = $urandom_range(1, 3);
      model();
      start_seq();
      wait_end(5000, 1'b1);
      compare_model($sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cam_reg_sequencer.md
CAM_REG_SEQUENCER -- requirements
Module: cam_reg_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, 8, camera register address width.
REQ-002 SHALL have parameter DATA_W, 8, camera register data width.
REQ-003 SHALL have parameter DEPTH, 256, max table entries; index width IDX_W = clog2(DEPTH).
REQ-004 SHALL have parameter MAX_RETRY, 3, retries per entry after NACK.
REQ-005 SHALL have parameter TICKS_PER_MS, 25000, clk cycles per delay millisecond.
REQ-006 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have port start  in  1  one-cycle pulse; (re)starts the sequence from index 0.
REQ-009 SHALL have port tbl_addr  out  IDX_W  table read index.
REQ-010 SHALL have port tbl_data  in  ADDR_W+DATA_W  entry {reg_addr, reg_data}, valid one cycle after tbl_addr changes.
REQ-011 SHALL have ports cmd_valid out 1, cmd_ready in 1, cmd_addr out ADDR_W, cmd_data out DATA_W: write request to bus master.
REQ-012 SHALL have ports rsp_valid in 1, rsp_nack in 1: one-cycle completion from bus master, nack=1 on failure.
REQ-013 SHALL have outputs busy 1, done 1, error 1, err_idx IDX_W.

Function
REQ-014 SHALL implement states IDLE, FETCH, DECODE, ISSUE, WAIT_RSP, DELAY, DONE, ERR.
REQ-015 IDLE/DONE/ERR + start -> FETCH with index=0, retry count=0, done=0, error=0.
REQ-016 FETCH: drive tbl_addr=index, go DECODE next cycle (1-cycle ROM latency).
REQ-017 DECODE: reg_addr all-ones and reg_data all-ones -> DONE (end marker); reg_addr all-ones, other data -> DELAY (when delay feature compiled in); else latch cmd_addr/cmd_data, -> ISSUE.
REQ-018 ISSUE: cmd_valid=1, cmd_addr/cmd_data stable until cycle where cmd_valid&cmd_ready, then -> WAIT_RSP, cmd_valid=0 next cycle.
REQ-019 WAIT_RSP, rsp_valid&!rsp_nack: index+1, retry=0; index was DEPTH-1 -> DONE, else -> FETCH.
REQ-020 WAIT_RSP, rsp_valid&rsp_nack: retry<MAX_RETRY -> retry+1, -> ISSUE same entry; else -> ERR, err_idx=index.
REQ-021 DELAY: wait reg_data*TICKS_PER_MS cycles (reg_data=0 -> exactly one cycle), then index+1 -> FETCH (or DONE at DEPTH-1).
REQ-022 busy=1 in FETCH, DECODE, ISSUE, WAIT_RSP, DELAY; 0 otherwise.
REQ-023 done=1 and error=1 are held levels in DONE/ERR until next start or reset.
REQ-024 start in any busy state SHALL abort: next state FETCH, index=0, cmd_valid=0 next cycle; in-flight rsp_valid ignored.
REQ-025 rsp_valid outside WAIT_RSP and cmd_ready outside ISSUE SHALL be ignored.
REQ-026 index SHALL never wrap; DEPTH reached without end marker ends in DONE.
REQ-027 Delay counter SHALL be wide enough for (2^DATA_W-1)*TICKS_PER_MS without overflow.

Reset
REQ-028 rst_n=0 SHALL force IDLE immediately; index=0, retry=0, delay counter=0, tbl_addr=0, cmd_valid=0, cmd_addr=0, cmd_data=0, busy=0, done=0, error=0, err_idx=0.
REQ-029 After rst_n release, block SHALL stay in IDLE until start.

Configuration
REQ-030 Macro CAM_SEQ_DELAY_EN defined: delay entries per REQ-017/REQ-021 active.
REQ-031 Macro CAM_SEQ_DELAY_EN undefined: no DELAY state or counter; reg_addr all-ones with data not all-ones issued as ordinary write; end marker unchanged.

Verification
REQ-032 Table {12 80},{12 04},{FF FF}, cmd_ready=1, rsp ack 2 cycles after handshake -> exactly two writes 0x12/0x80, 0x12/0x04, then done=1, busy=0.
REQ-033 cmd_ready low 5 cycles in ISSUE -> cmd_valid held, cmd_addr/cmd_data unchanged all 5 cycles, single handshake.
REQ-034 MAX_RETRY=3, entry 2 always NACK -> 4 attempts at entry 2, then error=1, err_idx=2, no entry-3 fetch.
REQ-035 With CAM_SEQ_DELAY_EN, TICKS_PER_MS=10, entry {FF 03} -> 30-cycle gap with cmd_valid=0 before next write; without macro -> write 0xFF/0x03 issued.
REQ-036 start pulse during WAIT_RSP of entry 5 -> next tbl_addr=0, late rsp_valid ignored, sequence completes from 0.
REQ-037 rst_n low mid-ISSUE -> cmd_valid=0 and busy=0 same cycle, all outputs at REQ-028 values.
